// File: rtl/iddr_deser.sv
// Multi-lane DDR input register: rise/fall pair outputs in a selectable edge mode,
// plus a per-lane RATIO:1 deserialiser with valid strobe and 2-bit bitslip.
module iddr_deser #(
    parameter int    LANES          = 1,
    parameter int    RATIO          = 4,
    parameter string DDR_CLK_EDGE   = "OPPOSITE_EDGE",
    parameter bit    IS_C_INVERTED  = 1'b0,
    parameter bit    DATA_MSB_FIRST = 1'b1
) (
    input  logic                   C,
    input  logic                   R,
    input  logic [LANES-1:0]       D,
    input  logic                   BITSLIP,
    output logic [LANES-1:0]       Q1,
    output logic [LANES-1:0]       Q2,
    output logic [LANES*RATIO-1:0] Q,
    output logic                   Q_VALID
);

    localparam int PAIRS = RATIO / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int GW    = $clog2(PAIRS + 2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PAIRS - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(PAIRS + 1);

    if (RATIO != 2 && RATIO != 4 && RATIO != 8) begin : g_bad_ratio
        $error("iddr_deser: RATIO must be 2, 4 or 8 (got %0d)", RATIO);
    end
    if (LANES < 1 || LANES > 32) begin : g_bad_lanes
        $error("iddr_deser: LANES must be 1..32 (got %0d)", LANES);
    end

    logic clk;
    assign clk = C ^ IS_C_INVERTED;

    logic [LANES-1:0] rs_q;
    logic [LANES-1:0] fs_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge R) begin
        if (R) rs_q <= '0;
        else   rs_q <= D;
    end

    always_ff @(negedge clk or posedge R) begin
        if (R) fs_q <= '0;
        else   fs_q <= D;
    end

    if (DDR_CLK_EDGE == "OPPOSITE_EDGE") begin : g_opposite
        assign Q1 = rs_q;
        assign Q2 = fs_q;
    end else if (DDR_CLK_EDGE == "SAME_EDGE") begin : g_same
        logic [LANES-1:0] q2_q;
        always_ff @(posedge clk or posedge R) begin
            if (R) q2_q <= '0;
            else   q2_q <= fs_q;
        end
        assign Q1 = rs_q;
        assign Q2 = q2_q;
    end else if (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED") begin : g_pipelined
        logic [LANES-1:0] q1_q;
        logic [LANES-1:0] q2_q;
        always_ff @(posedge clk or posedge R) begin
            if (R) begin
                q1_q <= '0;
                q2_q <= '0;
            end else begin
                q1_q <= rs_q;
                q2_q <= fs_q;
            end
        end
        assign Q1 = q1_q;
        assign Q2 = q2_q;
    end else begin : g_bad_edge
        $error("iddr_deser: unknown DDR_CLK_EDGE \"%s\"", DDR_CLK_EDGE);
        assign Q1 = '0;
        assign Q2 = '0;
    end

    // Deserialiser always consumes the aligned pair (rs(k-1), fs(k-1)) held in rs_q/fs_q.
    logic                   primed;
    logic [CW-1:0]          cnt;
    logic [GW-1:0]          guard;
    logic [LANES*RATIO-1:0] sr_q;
    logic [LANES*RATIO-1:0] sr_next;
    logic                   slip;
    logic                   word_done;

    assign slip      = BITSLIP && primed && (guard == '0);
    assign word_done = primed && !slip && (cnt == CNT_LAST);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        if (RATIO == 2) begin : g_r2
            if (DATA_MSB_FIRST) begin : g_msb
                assign sr_next[l*RATIO +: RATIO] = {rs_q[l], fs_q[l]};
            end else begin : g_lsb
                assign sr_next[l*RATIO +: RATIO] = {fs_q[l], rs_q[l]};
            end
        end else if (DATA_MSB_FIRST) begin : g_msb
            assign sr_next[l*RATIO +: RATIO] = {sr_q[l*RATIO +: RATIO-2], rs_q[l], fs_q[l]};
        end else begin : g_lsb
            assign sr_next[l*RATIO +: RATIO] = {fs_q[l], rs_q[l], sr_q[l*RATIO+2 +: RATIO-2]};
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            primed  <= 1'b0;
            cnt     <= '0;
            guard   <= '0;
            sr_q    <= '0;
            Q       <= '0;
            Q_VALID <= 1'b0;
        end else begin
            primed  <= 1'b1;
            Q_VALID <= word_done;
            if (slip)
                guard <= GUARD_LOAD;
            else if (guard != '0)
                guard <= guard - 1'b1;
            // A slip shifts the pair but freezes the counter, moving the boundary one pair later.
            if (primed) begin
                sr_q <= sr_next;
                if (!slip)
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (word_done)
                Q <= sr_next;
        end
    end

endmodule
